pc_fetch_unit: RTL and testbench

- Program-counter and instruction-fetch stage of the RV32I core.
- Consumes nextPcSrc from branchUnit and the branch/jump target from the ALU, and holds the PC register.
- Runs a one-outstanding request/response fetch to instruction memory and presents the fetched instruction plus its PC to decode.
- Advances only when the downstream execute path signals completion.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/pc_fetch_unit.sv | 147 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I program-counter / fetch stage.
//   fetch_state_t : fetch FSM encoding. S_TRAP is reachable only when the
//                   design is built with MISALIGN_TRAP_EN.
//   INST_NOP      : canonical NOP (addi x0, x0, 0), presented to decode
//                   while no instruction has been fetched since reset.
//   PC_STEP       : sequential PC increment, in bytes.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_TRAP = 2'd2
  } fetch_state_t;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch for the RV32I core.
//
// Runs a single-outstanding fetch to instruction memory, holds the fetched
// instruction and its PC for decode, and advances the PC only when execute
// reports completion.
//
// Optional build macro: MISALIGN_TRAP_EN
//   defined   : a taken branch/jump whose target has bit 1 set does not
//               update the PC; fetchMisalign latches high and the unit parks
//               in S_TRAP until reset.
//   undefined : target bits [1:0] are silently cleared; fetchMisalign is 0.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_REQ  | imemReq high at address pc; waiting for imemRvalid
// S_HOLD | inst/pc valid for decode; waiting for execDone
// S_TRAP | misaligned target seen; no fetch, no valid, until reset
//
// Ports
//   clk, rst       core clock (rising edge), async active-high reset
//   nextPcSrc      1 = take brTarget, 0 = sequential (valid with execDone)
//   brTarget       branch/jump target from the ALU
//   execDone       current instruction finished this cycle
//   imemRdata      instruction-memory read data
//   imemRvalid     read data valid for the outstanding request
//   imemReq        fetch request, level, held until imemRvalid
//   imemAddr       fetch address (always pc)
//   inst, pc       instruction for decode and its address
//   pcPlus4        pc + 4 for link writeback
//   instValid      inst/pc valid
//   fetchMisalign  sticky misaligned-target trap flag
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned           XLEN     = 32,
  parameter logic [XLEN-1:0]       RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            nextPcSrc,
  input  logic [XLEN-1:0] brTarget,
  input  logic            execDone,
  input  logic [XLEN-1:0] imemRdata,
  input  logic            imemRvalid,
  output logic            imemReq,
  output logic [XLEN-1:0] imemAddr,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcPlus4,
  output logic            instValid,
  output logic            fetchMisalign
);

  fetch_state_t    state, state_nx;
  logic [XLEN-1:0] pc_nx;
  logic [XLEN-1:0] inst_nx;
  logic [XLEN-1:0] next_pc;

  // Next-PC mux. JALR clears bit 0; the word-aligned fetch also drops bit 1.
  // The sequential add wraps naturally at 2^32.
  always_comb begin
    next_pc = pc + PC_STEP;
    if (nextPcSrc) begin
      next_pc = {brTarget[XLEN-1:1], 1'b0} & ~32'h3;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_q, misalign_nx;
`endif

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    inst_nx  = inst;
`ifdef MISALIGN_TRAP_EN
    misalign_nx = misalign_q;
`endif
    case (state)
      S_REQ: begin
        // execDone is meaningless here: nothing is in execute yet.
        if (imemRvalid) begin
          inst_nx  = imemRdata;
          state_nx = S_HOLD;
        end
      end
      S_HOLD: begin
        // A stray imemRvalid here has no request behind it and is dropped.
        if (execDone) begin
`ifdef MISALIGN_TRAP_EN
          if (nextPcSrc && brTarget[1]) begin
            misalign_nx = 1'b1;
            state_nx    = S_TRAP;
          end else begin
            pc_nx    = next_pc;
            state_nx = S_REQ;
          end
`else
          pc_nx    = next_pc;
          state_nx = S_REQ;
`endif
        end
      end
`ifdef MISALIGN_TRAP_EN
      S_TRAP: begin
        state_nx = S_TRAP;
      end
`endif
      default: begin
        state_nx = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_REQ;
      pc    <= RESET_PC;
      inst  <= INST_NOP;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      inst  <= inst_nx;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_nx;
    end
  end
  assign fetchMisalign = misalign_q;
`else
  assign fetchMisalign = 1'b0;
`endif

  // Gating with rst keeps the request low during reset and lets it rise
  // combinationally in the first cycle after release.
  assign imemReq   = (state == S_REQ) && !rst;
  assign imemAddr  = pc;
  assign pcPlus4   = pc + PC_STEP;
  assign instValid = (state == S_HOLD);

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        nextPcSrc = 1'b0;
  logic [31:0] brTarget = 32'h0;
  logic        execDone = 1'b0;
  logic [31:0] imemRdata = 32'h0;
  logic        imemRvalid = 1'b0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        instValid;
  logic        fetchMisalign;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_pc;

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .nextPcSrc    (nextPcSrc),
    .brTarget     (brTarget),
    .execDone     (execDone),
    .imemRdata    (imemRdata),
    .imemRvalid   (imemRvalid),
    .imemReq      (imemReq),
    .imemAddr     (imemAddr),
    .inst         (inst),
    .pc           (pc),
    .pcPlus4      (pcPlus4),
    .instValid    (instValid),
    .fetchMisalign(fetchMisalign)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Completes one fetch at exp_pc after 'waits' idle memory cycles.
  // With 'poke' set, execDone is pulsed during the wait to show it is ignored.
  task automatic fetch(input logic [31:0] data, input int waits, input bit poke);
    logic [31:0] addr0;
    addr0 = imemAddr;
    chk("req_addr", imemAddr, exp_pc);
    for (int i = 0; i < waits; i++) begin
      execDone = poke;
      chk("wait_req", {31'd0, imemReq}, 32'd1);
      chk("wait_addr", imemAddr, addr0);
      chk("wait_valid", {31'd0, instValid}, 32'd0);
      tick();
      chk("wait_pc", pc, exp_pc);
    end
    execDone   = 1'b0;
    imemRdata  = data;
    imemRvalid = 1'b1;
    tick();
    imemRvalid = 1'b0;
    chk("hold_valid", {31'd0, instValid}, 32'd1);
    chk("hold_inst", inst, data);
    chk("hold_pc", pc, exp_pc);
    chk("hold_pc4", pcPlus4, exp_pc + 32'd4);
    chk("hold_noreq", {31'd0, imemReq}, 32'd0);
  endtask

  task automatic exec(input logic src, input logic [31:0] tgt, input logic [31:0] nxt);
    nextPcSrc = src;
    brTarget  = tgt;
    execDone  = 1'b1;
    tick();
    execDone  = 1'b0;
    nextPcSrc = 1'b0;
    exp_pc    = nxt;
    chk("next_pc", pc, exp_pc);
    chk("next_addr", imemAddr, exp_pc);
    chk("next_valid_drop", {31'd0, instValid}, 32'd0);
    chk("next_req", {31'd0, imemReq}, 32'd1);
  endtask

  initial begin
    exp_pc = 32'h0;
    // reset state
    tick();
    chk("rst_req", {31'd0, imemReq}, 32'd0);
    chk("rst_valid", {31'd0, instValid}, 32'd0);
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_pc", pc, 32'h0);
    chk("rst_mis", {31'd0, fetchMisalign}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_req", {31'd0, imemReq}, 32'd1);

    // rvalid one cycle after req, then sequential run 0,4,8,C
    fetch(32'hA000_0000, 1, 1'b0);
    exec(1'b0, 32'h0, 32'h4);
    fetch(32'hA000_0004, 0, 1'b0);
    exec(1'b0, 32'h0, 32'h8);
    fetch(32'hA000_0008, 0, 1'b0);
    exec(1'b0, 32'h0, 32'hC);
    fetch(32'hA000_000C, 0, 1'b0);

    // branch to 0x20 (bit 0 of target dropped)
    exec(1'b1, 32'h0000_0021, 32'h20);
    fetch(32'hA000_0020, 0, 1'b0);

`ifndef MISALIGN_TRAP_EN
    // taken branch to 0x103 -> 0x100, no trap
    exec(1'b1, 32'h0000_0103, 32'h100);
    chk("br_nomis", {31'd0, fetchMisalign}, 32'd0);
    // 5-cycle memory stall with ignored execDone
    fetch(32'hA000_0100, 5, 1'b1);
`else
    exec(1'b1, 32'h0000_0100, 32'h100);
    fetch(32'hA000_0100, 5, 1'b1);
`endif

    // wrap at top of address space
    exec(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    fetch(32'hA000_FFFC, 0, 1'b0);
    chk("wrap_pc4", pcPlus4, 32'h0);
    exec(1'b0, 32'h0, 32'h0);
    fetch(32'hA000_0000, 0, 1'b0);
    exec(1'b0, 32'h0, 32'h4);
    fetch(32'hB000_0004, 0, 1'b0);

    // stray rvalid in S_HOLD
    imemRdata  = 32'hDEAD_BEEF;
    imemRvalid = 1'b1;
    tick();
    imemRvalid = 1'b0;
    chk("stray_inst", inst, 32'hB000_0004);
    chk("stray_valid", {31'd0, instValid}, 32'd1);

    // async reset in S_HOLD, mid-cycle
    #2;
    rst = 1'b1;
    #1;
    chk("arst_hold_pc", pc, 32'h0);
    chk("arst_hold_valid", {31'd0, instValid}, 32'd0);
    chk("arst_hold_inst", inst, 32'h0000_0013);
    chk("arst_hold_req", {31'd0, imemReq}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    exp_pc = 32'h0;
    fetch(32'hC000_0000, 0, 1'b0);
    exec(1'b0, 32'h0, 32'h4);

    // async reset while waiting for memory
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_wait_pc", pc, 32'h0);
    chk("arst_wait_req", {31'd0, imemReq}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    exp_pc = 32'h0;
    fetch(32'hC100_0000, 1, 1'b0);

`ifdef MISALIGN_TRAP_EN
    exec(1'b1, 32'h0000_0020, 32'h20);
    fetch(32'hA000_0020, 0, 1'b0);
    nextPcSrc = 1'b1;
    brTarget  = 32'h0000_0102;
    execDone  = 1'b1;
    tick();
    execDone  = 1'b0;
    nextPcSrc = 1'b0;
    tick();
    chk("trap_mis", {31'd0, fetchMisalign}, 32'd1);
    chk("trap_req", {31'd0, imemReq}, 32'd0);
    chk("trap_pc", pc, 32'h20);
    chk("trap_valid", {31'd0, instValid}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
